// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory responder for the core. Word-addressed SRAM model
// behind a req/ready handshake that answers each access after WAIT_CYCLES wait states.
//
// Ports:
//   CLK    in   1   clock, rising edge
//   Reset  in   1   asynchronous active-low reset
//   req    in   1   transfer request, sampled only while idle
//   we     in   1   1 = store, 0 = load, sampled with req
//   addr   in   32  byte address, sampled with req
//   wdata  in   32  store data, sampled with req
//   rdata  out  32  response data, held until the next response
//   ready  out  1   one-cycle response pulse
//   err    out  1   illegal access flag, valid with ready
//   busy   out  1   transfer in flight (state not idle)

module data_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        w_latch;
    logic        w_enter_resp;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_ready;
    logic        r_err;
    logic        r_busy;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_legal;
    logic [AW-1:0] w_idx;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_latch      = 1'b0;
        w_enter_resp = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_latch = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_next       = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_next     = S_WAIT;
                        w_cnt_next = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next       = S_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // With zero wait states the response edge is the sampling edge, so the
    // access must come straight from the inputs rather than the latches.
    assign w_we    = (r_state == S_IDLE) ? we    : r_we;
    assign w_addr  = (r_state == S_IDLE) ? addr  : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? wdata : r_wdata;

    // No wrap-around: every bit above the word index must be zero.
    assign w_legal = (w_addr[1:0] == 2'b00) &&
                     (w_addr[31:AW+2] == '0);
    assign w_idx   = w_addr[AW+1:2];

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else if (w_latch) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_rdata <= 32'd0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ready <= w_enter_resp;
            r_err   <= w_enter_resp && !w_legal;
            r_busy  <= (w_next != S_IDLE);
            if (w_enter_resp) begin
                if (!w_legal) begin
                    r_rdata <= 32'd0;
                end else if (w_we) begin
                    r_rdata <= w_wdata;
                end else begin
                    r_rdata <= r_mem[w_idx];
                end
            end
        end
    end

    // Array is never cleared; gating on Reset keeps an aborted store out.
    always_ff @(posedge CLK) begin
        if (Reset && w_enter_resp && w_legal && w_we) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    assign rdata = r_rdata;
    assign ready = r_ready;
    assign err   = r_err;
    assign busy  = r_busy;

endmodule
